// File: rtl/coeff_loader.sv
// coeff_loader: streams one band's 64 FIR coefficients from a synchronous
// coefficient ROM into a serial filter's load port, then pulses write_done.
// Optional build macro COEFF_LOADER_SYMMETRIC_EN: read only taps 0..31 and
// write each value to tap k and its mirror 63-k (linear-phase filters).
module coeff_loader #(
  parameter int COEFF_WIDTH    = 16,
  parameter int TAP_ADDR_WIDTH = 6,
  parameter int BAND_WIDTH     = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clk_enable,
  input  logic                                 i_start,
  input  logic [BAND_WIDTH-1:0]                i_band,
  output logic                                 o_rom_en,
  output logic [BAND_WIDTH+TAP_ADDR_WIDTH-1:0] o_rom_address,
  input  logic signed [COEFF_WIDTH-1:0]        i_rom_data,
  output logic                                 o_write_enable,
  output logic [TAP_ADDR_WIDTH-1:0]            o_write_address,
  output logic signed [COEFF_WIDTH-1:0]        o_coeffs_in,
  output logic                                 o_write_done,
  output logic                                 o_busy
);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;

  localparam logic [TAP_ADDR_WIDTH-1:0] TAP_ONE  = 1;
  localparam logic [TAP_ADDR_WIDTH-1:0] TAP_LAST = '1;
  localparam logic [TAP_ADDR_WIDTH:0]   CNT_ONE  = 1;
`ifdef COEFF_LOADER_SYMMETRIC_EN
  localparam logic [TAP_ADDR_WIDTH-1:0] ROM_TAP_LAST = TAP_LAST >> 1;
`endif

  state_t                            state, state_next;
  logic [BAND_WIDTH-1:0]             band, band_next;
  logic [TAP_ADDR_WIDTH-1:0]         tap_cnt, tap_cnt_next, tap_inc;
  logic                              tap_wrap;
  logic [TAP_ADDR_WIDTH-1:0]         rom_tap, rom_tap_next;
  logic                              rom_en_next, we_next, done_next, busy_next;
  logic [TAP_ADDR_WIDTH-1:0]         wa_next;
  logic signed [COEFF_WIDTH-1:0]     coeff_next;
`ifdef COEFF_LOADER_SYMMETRIC_EN
  logic [TAP_ADDR_WIDTH-1:0]         pair;
  assign pair = tap_cnt >> 1;
`endif

  // Write counter increment; the carry out (63 -> 0 wrap) ends the stream.
  assign {tap_wrap, tap_inc} = {1'b0, tap_cnt} + CNT_ONE;

  assign o_rom_address = {band, rom_tap};

  // State register: reset wins over everything, otherwise advance on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (i_start) state_next = PREFETCH;
      PREFETCH: state_next = STREAM;
      STREAM:   if (tap_wrap) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath counters.
  always_comb begin
    band_next    = band;
    tap_cnt_next = tap_cnt;
    rom_tap_next = rom_tap;
    rom_en_next  = o_rom_en;
    we_next      = 1'b0;
    wa_next      = o_write_address;
    coeff_next   = o_coeffs_in;
    done_next    = 1'b0;
    busy_next    = o_busy;
    case (state)
      IDLE: begin
        if (i_start) begin
          band_next    = i_band;
          busy_next    = 1'b1;
          rom_tap_next = '0;
          rom_en_next  = 1'b1;
          tap_cnt_next = '0;
        end else begin
          busy_next = 1'b0;
        end
      end
      PREFETCH: begin
`ifdef COEFF_LOADER_SYMMETRIC_EN
        // Tap 0 is read once; the next read waits for the first pair write.
        rom_en_next = 1'b0;
`else
        rom_tap_next = rom_tap + TAP_ONE;
        rom_en_next  = 1'b1;
`endif
      end
      STREAM: begin
        we_next      = 1'b1;
        tap_cnt_next = tap_inc;
`ifdef COEFF_LOADER_SYMMETRIC_EN
        // Even count: fresh ROM word to tap k. Odd count: same word re-sent
        // to mirror tap 63-k, so the ROM is only strobed on even counts.
        wa_next    = tap_cnt[0] ? (TAP_LAST - pair) : pair;
        coeff_next = tap_cnt[0] ? o_coeffs_in : i_rom_data;
        if (!tap_cnt[0] && rom_tap != ROM_TAP_LAST) begin
          rom_tap_next = rom_tap + TAP_ONE;
          rom_en_next  = 1'b1;
        end else begin
          rom_en_next = 1'b0;
        end
`else
        wa_next    = tap_cnt;
        coeff_next = i_rom_data;
        if (o_rom_en && rom_tap != TAP_LAST) begin
          rom_tap_next = rom_tap + TAP_ONE;
        end else begin
          rom_en_next = 1'b0;
        end
`endif
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      band            <= '0;
      tap_cnt         <= '0;
      rom_tap         <= '0;
      o_rom_en        <= 1'b0;
      o_write_enable  <= 1'b0;
      o_write_address <= '0;
      o_coeffs_in     <= '0;
      o_write_done    <= 1'b0;
      o_busy          <= 1'b0;
    end else if (clk_enable) begin
      band            <= band_next;
      tap_cnt         <= tap_cnt_next;
      rom_tap         <= rom_tap_next;
      o_rom_en        <= rom_en_next;
      o_write_enable  <= we_next;
      o_write_address <= wa_next;
      o_coeffs_in     <= coeff_next;
      o_write_done    <= done_next;
      o_busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: ROM model returns {band<<8 | tap};
// expected writes are queued at start and popped as the DUT writes them.
module tb_coeff_loader;

  localparam int CW = 16;
  localparam int AW = 6;
  localparam int BW = 3;
`ifdef COEFF_LOADER_SYMMETRIC_EN
  localparam int EXP_READS = 32;
`else
  localparam int EXP_READS = 64;
`endif

  logic              clk = 1'b0;
  logic              rst, clk_enable, i_start;
  logic [BW-1:0]     i_band;
  logic              o_rom_en;
  logic [BW+AW-1:0]  o_rom_address;
  logic signed [CW-1:0] i_rom_data = '0;
  logic              o_write_enable;
  logic [AW-1:0]     o_write_address;
  logic signed [CW-1:0] o_coeffs_in;
  logic              o_write_done, o_busy;
  logic [34:0]       outs;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   total = 0;
  int   bad = 0;
  int   rom_reads = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  logic en_edge = 1'b0;

  coeff_loader #(.COEFF_WIDTH(CW), .TAP_ADDR_WIDTH(AW), .BAND_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .i_start(i_start),
    .i_band(i_band), .o_rom_en(o_rom_en), .o_rom_address(o_rom_address),
    .i_rom_data(i_rom_data), .o_write_enable(o_write_enable),
    .o_write_address(o_write_address), .o_coeffs_in(o_coeffs_in),
    .o_write_done(o_write_done), .o_busy(o_busy)
  );

  assign outs = {o_rom_en, o_rom_address, o_write_enable, o_write_address,
                 o_coeffs_in, o_write_done, o_busy};

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] rom_word(input logic [BW+AW-1:0] a);
    return (16'(a[8:6]) << 8) | 16'(a[5:0]);
  endfunction

  // Synchronous ROM model with read counter.
  always @(posedge clk) begin
    en_edge <= clk_enable;
    if (clk_enable && o_rom_en) begin
      i_rom_data <= rom_word(o_rom_address);
      rom_reads  <= rom_reads + 1;
    end
  end

  // Scoreboard: every write seen on an enabled edge is popped and compared.
  always @(negedge clk) begin
    if (en_edge && o_write_done) done_cnt++;
    if (en_edge && o_write_enable) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write addr=%0d data=%h required=no write",
                 o_write_address, o_coeffs_in);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_write_address !== mon_e.addr || o_coeffs_in !== mon_e.data) begin
          bad++;
          $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                   o_write_address, o_coeffs_in, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input logic [BW-1:0] b);
    for (int w = 0; w < 64; w++) begin
      wr_t e;
      int  p;
`ifdef COEFF_LOADER_SYMMETRIC_EN
      p = w / 2;
      e.addr = (w % 2 == 0) ? AW'(p) : AW'(63 - p);
`else
      p = w;
      e.addr = AW'(w);
`endif
      e.data = CW'(int'(b) * 256 + p);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_enable = 1'b0; i_start = 1'b1; i_band = 3'd5;
    tick(); tick();
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h required=0", outs);
    end
    rst = 1'b0; i_start = 1'b0; clk_enable = 1'b1;
    tick();
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_idle got=%h required=0", outs);
    end
  endtask

  task automatic test_load_basic();
    int r0, d0;
    logic ew, ed, eb;
    r0 = rom_reads; d0 = done_cnt;
    push_load(3'd3);
    i_band = 3'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_band = 3'd6;
    total++;
    if (o_rom_en !== 1'b1 || o_rom_address !== {3'd3, 6'd0}) begin
      bad++; $display("FAIL basic_first_read got en=%b addr=%h required en=1 addr=0c0",
                      o_rom_en, o_rom_address);
    end
    for (int e = 0; e <= 67; e++) begin
      ew = (e >= 2 && e <= 65); ed = (e == 66); eb = (e <= 66);
      total++;
      if ({o_write_enable, o_write_done, o_busy} !== {ew, ed, eb}) begin
        bad++; $display("FAIL basic_flags e=%0d got we/done/busy=%b%b%b required %b%b%b",
                        e, o_write_enable, o_write_done, o_busy, ew, ed, eb);
      end
      tick();
    end
    total++;
    if (rom_reads - r0 !== EXP_READS) begin
      bad++; $display("FAIL basic_rom_reads got=%0d required=%0d", rom_reads - r0, EXP_READS);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++; $display("FAIL basic_done_count got=%0d required=1", done_cnt - d0);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL basic_missing_writes got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clk_enable();
    int e, done_clk;
    logic [34:0] snap;
    logic ew, ed, eb;
    e = 0; done_clk = -1;
    push_load(3'd3);
    i_band = 3'd3; i_start = 1'b1; clk_enable = 1'b1;
    tick();
    i_start = 1'b0;
    snap = outs;
    for (int c = 1; c <= 140; c++) begin
      clk_enable = (c % 2 == 0);
      tick();
      if (!clk_enable) begin
        total++;
        if (outs !== snap) begin
          bad++; $display("FAIL gated_hold c=%0d got=%h required=%h", c, outs, snap);
        end
      end else begin
        e++;
        ew = (e >= 2 && e <= 65); ed = (e == 66); eb = (e <= 66);
        total++;
        if ({o_write_enable, o_write_done, o_busy} !== {ew, ed, eb}) begin
          bad++; $display("FAIL gated_flags e=%0d got we/done/busy=%b%b%b required %b%b%b",
                          e, o_write_enable, o_write_done, o_busy, ew, ed, eb);
        end
        if (o_write_done && done_clk < 0) done_clk = c;
      end
      snap = outs;
    end
    clk_enable = 1'b1;
    total++;
    if (done_clk !== 132) begin
      bad++; $display("FAIL gated_done_clock got=%0d required=132", done_clk);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL gated_missing_writes got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    d0 = done_cnt;
    push_load(3'd3);
    i_band = 3'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int e = 0; e <= 67; e++) begin
      if (e == 22) begin i_start = 1'b1; i_band = 3'd5; end
      if (e == 23) i_start = 1'b0;
      tick();
    end
    tick();
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++; $display("FAIL ignore_done_count got=%0d required=1", done_cnt - d0);
    end
    total++;
    if (o_busy !== 1'b0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL ignore_no_requeue got busy=%b left=%0d required busy=0 left=0",
                      o_busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int d0, w0;
    logic ew, ed, eb;
    push_load(3'd3);
    i_band = 3'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int e = 0; e < 42; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL abort_outputs got=%h required=0", outs);
    end
    d0 = done_cnt; w0 = wr_cnt;
    for (int c = 0; c < 70; c++) tick();
    total++;
    if (done_cnt !== d0 || wr_cnt !== w0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet got done=%0d writes=%0d busy=%b required 0 0 0",
                      done_cnt - d0, wr_cnt - w0, o_busy);
    end
    push_load(3'd7);
    i_band = 3'd7; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int e = 0; e <= 67; e++) begin
      ew = (e >= 2 && e <= 65); ed = (e == 66); eb = (e <= 66);
      total++;
      if ({o_write_enable, o_write_done, o_busy} !== {ew, ed, eb}) begin
        bad++; $display("FAIL reload_flags e=%0d got we/done/busy=%b%b%b required %b%b%b",
                        e, o_write_enable, o_write_done, o_busy, ew, ed, eb);
      end
      tick();
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL reload_missing_writes got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic ew, ed, eb;
    d0 = done_cnt;
    push_load(3'd2);
    push_load(3'd2);
    i_band = 3'd2; i_start = 1'b1;
    tick();
    for (int e = 0; e <= 135; e++) begin
      ew = (e >= 2 && e <= 65) || (e >= 69 && e <= 132);
      ed = (e == 66) || (e == 133);
      eb = (e <= 133);
      total++;
      if ({o_write_enable, o_write_done, o_busy} !== {ew, ed, eb}) begin
        bad++; $display("FAIL b2b_flags e=%0d got we/done/busy=%b%b%b required %b%b%b",
                        e, o_write_enable, o_write_done, o_busy, ew, ed, eb);
      end
      if (e == 67) i_start = 1'b0;
      tick();
    end
    total++;
    if (done_cnt - d0 !== 2) begin
      bad++; $display("FAIL b2b_done_count got=%0d required=2", done_cnt - d0);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL b2b_missing_writes got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b0; i_start = 1'b0; i_band = '0;
    test_reset();
    test_load_basic();
    test_clk_enable();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
